// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    localparam int FETCH_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        FLUSH = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Slot mask and next fetch address from the same-cycle branch prediction.
module fetch_next_pc
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]  pc_i,
    input  logic [FETCH_WIDTH-1:0] pred_taken_i,
    input  logic [DATA_WIDTH-1:0]  pred_target_i,
    output logic [DATA_WIDTH-1:0]  next_pc_o,
    output logic [FETCH_WIDTH-1:0] slot_mask_o
);

    localparam logic [DATA_WIDTH-1:0] STRIDE = DATA_WIDTH'(FETCH_WIDTH * 4);

    logic found;

    // Slots up to and including the lowest taken one stay valid; all valid if none taken.
    always_comb begin
        found       = 1'b0;
        slot_mask_o = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            slot_mask_o[i] = !found;
            if (pred_taken_i[i]) found = 1'b1;
        end
    end

    assign next_pc_o = (|pred_taken_i) ? pred_target_i : pc_i + STRIDE;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: issues 3-wide fetch requests under buffer credit, handles stalls and redirects.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                     DATA_WIDTH   = 32,
    parameter int                     BUFFER_DEPTH = 16,
    parameter logic [DATA_WIDTH-1:0]  RESET_PC     = 32'h8000_0000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [$clog2(BUFFER_DEPTH):0] occupancy_i,
    input  logic                          buble_i,
    input  logic                          redirect_valid_i,
    input  logic [DATA_WIDTH-1:0]         redirect_pc_i,
    input  logic [FETCH_WIDTH-1:0]        pred_taken_i,
    input  logic [DATA_WIDTH-1:0]         pred_target_i,
    output logic [DATA_WIDTH-1:0]         fetch_pc_o,
    output logic                          fetch_req_o,
    output logic [FETCH_WIDTH-1:0]        rsp_valid_o,
    output logic                          buffer_flush_o,
    output logic [1:0]                    state_o
);

    localparam logic [31:0] FW    = 32'(FETCH_WIDTH);
    localparam logic [31:0] DEPTH = 32'(BUFFER_DEPTH);

    fetch_state_e state_q, state_d;
    logic [DATA_WIDTH-1:0]  pc_q, pc_d;
    logic [FETCH_WIDTH-1:0] mask_q, mask_d;
    logic                   inflight_q;
    logic                   flush_q;

    logic [DATA_WIDTH-1:0]  next_pc;
    logic [FETCH_WIDTH-1:0] slot_mask;
    logic [31:0]            occ_eff;
    logic [31:0]            need;
    logic                   req_ok;

    fetch_next_pc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_next_pc (
        .pc_i          (pc_q),
        .pred_taken_i  (pred_taken_i),
        .pred_target_i (pred_target_i),
        .next_pc_o     (next_pc),
        .slot_mask_o   (slot_mask)
    );

    // The buffer was just cleared by FLUSH, so the reported occupancy is stale for one cycle.
    assign occ_eff = flush_q ? 32'd0 : 32'(occupancy_i);
    assign need    = occ_eff + (inflight_q ? FW : 32'd0) + FW;
    assign req_ok  = (need <= DEPTH) && !buble_i && !redirect_valid_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            mask_q     <= '0;
            inflight_q <= 1'b0;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mask_q     <= mask_d;
            inflight_q <= fetch_req_o;
            flush_q    <= (state_q == FLUSH);
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_valid_i) begin
            state_d = FLUSH;
        end else begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = req_ok ? RUN : STALL;
                STALL:   state_d = req_ok ? RUN : STALL;
                FLUSH:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        fetch_req_o    = (state_q == RUN) && req_ok;
        buffer_flush_o = (state_q == FLUSH);
    end

    always_comb begin
        pc_d   = pc_q;
        mask_d = '0;
        if (redirect_valid_i) begin
            pc_d = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
        end else if (fetch_req_o) begin
            pc_d   = next_pc;
            mask_d = slot_mask;
        end
    end

    assign fetch_pc_o  = pc_q;
    assign rsp_valid_o = mask_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with hand-computed expectations.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  occupancy_i;
    logic        buble_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic [2:0]  pred_taken_i;
    logic [31:0] pred_target_i;
    logic [31:0] fetch_pc_o;
    logic        fetch_req_o;
    logic [2:0]  rsp_valid_o;
    logic        buffer_flush_o;
    logic [1:0]  state_o;

    int n_total = 0;
    int n_bad   = 0;

    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_STALL = 2'd2, S_FLUSH = 2'd3;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .occupancy_i      (occupancy_i),
        .buble_i          (buble_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .pred_taken_i     (pred_taken_i),
        .pred_target_i    (pred_target_i),
        .fetch_pc_o       (fetch_pc_o),
        .fetch_req_o      (fetch_req_o),
        .rsp_valid_o      (rsp_valid_o),
        .buffer_flush_o   (buffer_flush_o),
        .state_o          (state_o)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_cyc(input string tag, input logic [1:0] st, input logic [31:0] pc,
                             input logic req, input logic [2:0] rsp, input logic fl);
        check_val({tag, ".state"}, 32'(state_o), 32'(st));
        check_val({tag, ".pc"},    fetch_pc_o, pc);
        check_val({tag, ".req"},   32'(fetch_req_o), 32'(req));
        check_val({tag, ".rsp"},   32'(rsp_valid_o), 32'(rsp));
        check_val({tag, ".flush"}, 32'(buffer_flush_o), 32'(fl));
    endtask

    initial begin
        reset = 1'b1; occupancy_i = '0; buble_i = 1'b0; redirect_valid_i = 1'b0;
        redirect_pc_i = '0; pred_taken_i = '0; pred_target_i = '0;

        @(negedge clk); @(negedge clk); #1;
        check_cyc("reset", S_IDLE, 32'h8000_0000, 1'b0, 3'b000, 1'b0);

        @(negedge clk); reset = 1'b0; #1;
        check_cyc("idle", S_IDLE, 32'h8000_0000, 1'b0, 3'b000, 1'b0);
        @(negedge clk); #1;
        check_cyc("run0", S_RUN, 32'h8000_0000, 1'b1, 3'b000, 1'b0);
        @(negedge clk); #1;
        check_cyc("run1", S_RUN, 32'h8000_000C, 1'b1, 3'b111, 1'b0);
        @(negedge clk); pred_taken_i = 3'b010; pred_target_i = 32'h8000_0040; #1;
        check_cyc("run2", S_RUN, 32'h8000_0018, 1'b1, 3'b111, 1'b0);

        // Prediction applied; credit fails with 11 + 3 inflight + 3
        @(negedge clk); pred_taken_i = 3'b000; occupancy_i = 5'd11; #1;
        check_cyc("pred", S_RUN, 32'h8000_0040, 1'b0, 3'b011, 1'b0);
        @(negedge clk); occupancy_i = 5'd7; #1;
        check_cyc("stall", S_STALL, 32'h8000_0040, 1'b0, 3'b000, 1'b0);
        @(negedge clk); #1;
        check_cyc("resume", S_RUN, 32'h8000_0040, 1'b1, 3'b000, 1'b0);

        // Full buffer holds the stall; DEPTH-3 issues only without inflight
        @(negedge clk); occupancy_i = 5'd16; #1;
        check_cyc("full", S_RUN, 32'h8000_004C, 1'b0, 3'b111, 1'b0);
        @(negedge clk); #1;
        check_cyc("full_st", S_STALL, 32'h8000_004C, 1'b0, 3'b000, 1'b0);
        @(negedge clk); occupancy_i = 5'd13; #1;
        check_cyc("full_st2", S_STALL, 32'h8000_004C, 1'b0, 3'b000, 1'b0);
        @(negedge clk); #1;
        check_cyc("d3_ok", S_RUN, 32'h8000_004C, 1'b1, 3'b000, 1'b0);
        @(negedge clk); #1;
        check_cyc("d3_inf", S_RUN, 32'h8000_0058, 1'b0, 3'b111, 1'b0);
        @(negedge clk); occupancy_i = 5'd0; #1;
        check_cyc("st_c1", S_STALL, 32'h8000_0058, 1'b0, 3'b000, 1'b0);
        @(negedge clk); #1;
        check_cyc("run_c2", S_RUN, 32'h8000_0058, 1'b1, 3'b000, 1'b0);

        // Redirect with a pending response
        @(negedge clk); redirect_valid_i = 1'b1; redirect_pc_i = 32'h8000_0123; #1;
        check_cyc("redir", S_RUN, 32'h8000_0064, 1'b0, 3'b111, 1'b0);
        @(negedge clk); redirect_valid_i = 1'b0; occupancy_i = 5'd15; #1;
        check_cyc("flush", S_FLUSH, 32'h8000_0120, 1'b0, 3'b000, 1'b1);
        @(negedge clk); occupancy_i = 5'd0; #1;
        check_cyc("postfl", S_RUN, 32'h8000_0120, 1'b1, 3'b000, 1'b0);

        // Redirect during FLUSH, and bubble together with redirect
        @(negedge clk); redirect_valid_i = 1'b1; redirect_pc_i = 32'h8000_0200; #1;
        check_cyc("redir2", S_RUN, 32'h8000_012C, 1'b0, 3'b111, 1'b0);
        @(negedge clk); redirect_pc_i = 32'h8000_0306; buble_i = 1'b1; #1;
        check_cyc("fl2", S_FLUSH, 32'h8000_0200, 1'b0, 3'b000, 1'b1);
        @(negedge clk); redirect_valid_i = 1'b0; buble_i = 1'b0; #1;
        check_cyc("fl3", S_FLUSH, 32'h8000_0304, 1'b0, 3'b000, 1'b1);
        @(negedge clk); #1;
        check_cyc("postfl3", S_RUN, 32'h8000_0304, 1'b1, 3'b000, 1'b0);

        // Bubble alone stalls; reset while in STALL
        @(negedge clk); buble_i = 1'b1; #1;
        check_cyc("bub", S_RUN, 32'h8000_0310, 1'b0, 3'b111, 1'b0);
        @(negedge clk); reset = 1'b1; #1;
        check_cyc("bub_st", S_STALL, 32'h8000_0310, 1'b0, 3'b000, 1'b0);
        @(negedge clk); reset = 1'b0; buble_i = 1'b0; #1;
        check_cyc("rst_st", S_IDLE, 32'h8000_0000, 1'b0, 3'b000, 1'b0);

        // Slot masks for slot 0 / slot 2 taken, and address wrap
        @(negedge clk); pred_taken_i = 3'b101; pred_target_i = 32'h8000_1000; #1;
        check_cyc("t0", S_RUN, 32'h8000_0000, 1'b1, 3'b000, 1'b0);
        @(negedge clk); pred_taken_i = 3'b100; pred_target_i = 32'hFFFF_FFF8; #1;
        check_cyc("t0_rsp", S_RUN, 32'h8000_1000, 1'b1, 3'b001, 1'b0);
        @(negedge clk); pred_taken_i = 3'b000; #1;
        check_cyc("t2_rsp", S_RUN, 32'hFFFF_FFF8, 1'b1, 3'b111, 1'b0);
        @(negedge clk); reset = 1'b1; #1;
        check_cyc("wrap", S_RUN, 32'h0000_0004, 1'b1, 3'b111, 1'b0);
        @(negedge clk); #1;
        check_cyc("rst_req", S_IDLE, 32'h8000_0000, 1'b0, 3'b000, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
